vec_seq: RTL and testbench



---
 rtl/vec_seq_pkg.sv | 46 ++++
 rtl/vec_seq_if.sv | 26 ++
 rtl/vec_seq.sv | 162 ++++++++++++++++
 tb/tb_vec_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// rtl/vec_seq_pkg.sv - shared op, entry-field and FSM encodings for the display-list sequencer
package vec_seq_pkg;

    localparam int ENTRY_W = 18;
    localparam int COORD_W = 8;
    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 16;
    localparam int X_MSB   = 15;
    localparam int X_LSB   = 8;
    localparam int Y_MSB   = 7;
    localparam int Y_LSB   = 0;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_MOVE = 2'd1,
        OP_DRAW = 2'd2,
        OP_END  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DECODE  = 3'd3,
        ST_GO      = 3'd4,
        ST_ARM     = 3'd5,
        ST_DRAWING = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    function automatic op_e entry_op(input entry_t e);
        return op_e'(e[OP_MSB:OP_LSB]);
    endfunction

    function automatic coord_t entry_x(input entry_t e);
        return e[X_MSB:X_LSB];
    endfunction

    function automatic coord_t entry_y(input entry_t e);
        return e[Y_MSB:Y_LSB];
    endfunction

endpackage

// File: rtl/vec_seq_if.sv
// rtl/vec_seq_if.sv - display-list read port and line-drawer go/busy handshake
interface vec_seq_if
    import vec_seq_pkg::*;
#(
    parameter int AW = 10
);
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    entry_t        rd_data;
    logic          ld_go;
    logic          ld_busy;
    coord_t        ld_stax;
    coord_t        ld_stay;
    coord_t        ld_endx;
    coord_t        ld_endy;

    modport master (
        output rd_addr, rd_en, ld_go, ld_stax, ld_stay, ld_endx, ld_endy,
        input  rd_data, ld_busy
    );

    modport slave (
        input  rd_addr, rd_en, ld_go, ld_stax, ld_stay, ld_endx, ld_endy,
        output rd_data, ld_busy
    );
endinterface

// File: rtl/vec_seq.sv
// rtl/vec_seq.sv - display-list sequencer driving the line drawer; VEC_SEQ_BLANK_EN adds a blank output
module vec_seq
    import vec_seq_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      frame_start,
    vec_seq_if.master bus,
    output logic      active,
    output logic      frame_done,
    output logic      overrun
`ifdef VEC_SEQ_BLANK_EN
    ,
    output logic      blank
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    coord_t        pen_x_q, pen_x_d, pen_y_q, pen_y_d;
    coord_t        end_x_q, end_x_d, end_y_q, end_y_d;
    logic          rd_en_q, rd_en_d;
    logic          ld_go_q, ld_go_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
`ifdef VEC_SEQ_BLANK_EN
    logic          blank_q, blank_d;
`endif

    logic last_addr;
    op_e  op;

    assign last_addr = (addr_q == {AW{1'b1}});
    assign op        = entry_op(bus.rd_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            pen_x_q   <= '0;
            pen_y_q   <= '0;
            end_x_q   <= '0;
            end_y_q   <= '0;
            rd_en_q   <= 1'b0;
            ld_go_q   <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef VEC_SEQ_BLANK_EN
            blank_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pen_x_q   <= pen_x_d;
            pen_y_q   <= pen_y_d;
            end_x_q   <= end_x_d;
            end_y_q   <= end_y_d;
            rd_en_q   <= rd_en_d;
            ld_go_q   <= ld_go_d;
            active_q  <= active_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef VEC_SEQ_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    // Advancing past the last entry ends the frame instead of wrapping to a new fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_NOP, OP_MOVE: state_d = last_addr ? ST_DONE : ST_FETCH;
                    OP_DRAW:         state_d = ST_GO;
                    default:         state_d = ST_DONE;
                endcase
            end
            ST_GO:      state_d = ST_ARM;
            ST_ARM:     state_d = ST_DRAWING;
            ST_DRAWING: if (!bus.ld_busy) state_d = last_addr ? ST_DONE : ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state cycle.
    always_comb begin
        addr_d    = addr_q;
        pen_x_d   = pen_x_q;
        pen_y_d   = pen_y_q;
        end_x_d   = end_x_q;
        end_y_d   = end_y_q;
        overrun_d = overrun_q;
        rd_en_d   = (state_d == ST_FETCH);
        ld_go_d   = (state_d == ST_GO);
        done_d    = (state_d == ST_DONE);
        active_d  = (state_d != ST_IDLE);
`ifdef VEC_SEQ_BLANK_EN
        blank_d   = !(state_d == ST_GO || state_d == ST_ARM || state_d == ST_DRAWING);
`endif
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d  = '0;
                    pen_x_d = '0;
                    pen_y_d = '0;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_NOP: begin
                        addr_d    = addr_q + 1'b1;
                        overrun_d = overrun_q | last_addr;
                    end
                    OP_MOVE: begin
                        pen_x_d   = entry_x(bus.rd_data);
                        pen_y_d   = entry_y(bus.rd_data);
                        addr_d    = addr_q + 1'b1;
                        overrun_d = overrun_q | last_addr;
                    end
                    OP_DRAW: begin
                        end_x_d = entry_x(bus.rd_data);
                        end_y_d = entry_y(bus.rd_data);
                    end
                    default: ;
                endcase
            end
            ST_DRAWING: begin
                if (!bus.ld_busy) begin
                    pen_x_d   = end_x_q;
                    pen_y_d   = end_y_q;
                    addr_d    = addr_q + 1'b1;
                    overrun_d = overrun_q | last_addr;
                end
            end
            default: ;
        endcase
    end

    assign bus.rd_addr = addr_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.ld_go   = ld_go_q;
    assign bus.ld_stax = pen_x_q;
    assign bus.ld_stay = pen_y_q;
    assign bus.ld_endx = end_x_q;
    assign bus.ld_endy = end_y_q;
    assign active      = active_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;
`ifdef VEC_SEQ_BLANK_EN
    assign blank       = blank_q;
`endif

endmodule

// File: tb/tb_vec_seq.sv
// tb/tb_vec_seq.sv - directed bench for vec_seq with list memory and line-drawer models
module tb_vec_seq;
    import vec_seq_pkg::*;

    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic active, frame_done, overrun;
`ifdef VEC_SEQ_BLANK_EN
    logic blank;
`endif

    vec_seq_if #(.AW(AW)) vif ();

    vec_seq #(.AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bus         (vif.master),
        .active      (active),
        .frame_done  (frame_done),
        .overrun     (overrun)
`ifdef VEC_SEQ_BLANK_EN
        ,
        .blank       (blank)
`endif
    );

    always #5 clk = ~clk;

    logic [17:0] mem [4];
    always @(posedge clk) if (vif.rd_en) vif.rd_data <= mem[vif.rd_addr];

    int seg_dur = 26;
    int busy_left = 0;
    always @(posedge clk) begin
        if (vif.ld_go)
            busy_left <= (vif.ld_endx == vif.ld_stax && vif.ld_endy == vif.ld_stay) ? 1 : seg_dur;
        else if (busy_left > 0)
            busy_left <= busy_left - 1;
    end
    assign vif.ld_busy = (busy_left != 0);

    int          go_cnt = 0, done_cnt = 0, stab_err = 0, blank_err = 0;
    logic [31:0] go_q [$];
    time         go_t [$];
    time         t_done = 0;
    int          blank_left = 0;
    int          bl_now;

    always @(negedge clk) begin
        if (vif.ld_go) begin
            go_cnt <= go_cnt + 1;
            go_q.push_back({vif.ld_stax, vif.ld_stay, vif.ld_endx, vif.ld_endy});
            go_t.push_back($time);
        end
        if (vif.ld_busy && active && go_q.size() > 0 &&
            {vif.ld_stax, vif.ld_stay, vif.ld_endx, vif.ld_endy} !== go_q[go_q.size()-1])
            stab_err <= stab_err + 1;
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= $time;
        end
        bl_now = blank_left;
        if (!rst_n)
            bl_now = 0;
        else if (vif.ld_go)
            bl_now = ((vif.ld_endx == vif.ld_stax && vif.ld_endy == vif.ld_stay) ? 1 : seg_dur) + 2;
`ifdef VEC_SEQ_BLANK_EN
        if (blank !== (bl_now == 0)) blank_err <= blank_err + 1;
`endif
        blank_left <= (bl_now > 0) ? bl_now - 1 : 0;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int cyc_of(input time t, input time t1);
        return int'((t - t1 - 5) / 10) + 1;
    endfunction

    function automatic logic [17:0] ent(input op_e op, input int x, input int y);
        return {op, 8'(x), 8'(y)};
    endfunction

    task automatic start_frame(input string tag, output time t1);
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        t1 = $time;
        #1 frame_start = 1'b0;
        check({tag, "_active_t1"}, active, 1);
        check({tag, "_rden_t1"}, vif.rd_en, 1);
        check({tag, "_addr_t1"}, 32'(vif.rd_addr), 0);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int i = 0;
        while (done_cnt == d0 && i < 300) begin
            tick(1);
            i++;
        end
        check({tag, "_done_seen"}, done_cnt > d0, 1);
        check({tag, "_active_at_done"}, active, 1);
        tick(1);
        check({tag, "_active_after_done"}, active, 0);
    endtask

    task automatic wait_busy(input string tag);
        int i = 0;
        while (!vif.ld_busy && i < 30) begin
            tick(1);
            i++;
        end
        check({tag, "_busy_seen"}, vif.ld_busy, 1);
    endtask

    function automatic logic [31:0] go_at(input int idx);
        return (go_q.size() > idx) ? go_q[idx] : 32'hdeadbeef;
    endfunction

    function automatic time go_time(input int idx);
        return (go_t.size() > idx) ? go_t[idx] : 0;
    endfunction

    task automatic load_list_a();
        mem[0] = ent(OP_MOVE, 10, 20);
        mem[1] = ent(OP_DRAW, 30, 5);
        mem[2] = ent(OP_END, 0, 0);
        mem[3] = ent(OP_NOP, 0, 0);
    endtask

    initial begin
        time t1;
        int  g0, d0, q0;

        tick(3);
        check("rst_addr", 32'(vif.rd_addr), 0);
        check("rst_strobes", {vif.rd_en, vif.ld_go, active, frame_done, overrun}, 0);
        check("rst_coords", {vif.ld_stax, vif.ld_stay, vif.ld_endx, vif.ld_endy}, 0);
`ifdef VEC_SEQ_BLANK_EN
        check("rst_blank", blank, 1);
`endif
        rst_n = 1'b1;
        tick(2);

        // MOVE(10,20) DRAW(30,5) END with a 26-cycle segment
        load_list_a();
        seg_dur = 26;
        g0 = go_cnt; d0 = done_cnt; q0 = go_q.size();
        start_frame("a", t1);
        wait_done("a", d0);
        check("a_done_cycle", cyc_of(t_done, t1), 38);
        check("a_go_cycle", cyc_of(go_time(q0), t1), 7);
        check("a_seg", go_at(q0), {8'd10, 8'd20, 8'd30, 8'd5});
        tick(50);
        check("a_go_count", go_cnt - g0, 1);
        check("a_done_count", done_cnt - d0, 1);
        check("a_overrun", overrun, 0);
        check("a_stable", stab_err, 0);

        // frame_start while active must be ignored
        g0 = go_cnt; d0 = done_cnt;
        start_frame("ign", t1);
        wait_busy("ign");
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        wait_done("ign", d0);
        check("ign_done_cycle", cyc_of(t_done, t1), 38);
        tick(50);
        check("ign_go_count", go_cnt - g0, 1);
        check("ign_done_count", done_cnt - d0, 1);

        // asynchronous reset while the drawer is busy
        start_frame("rst", t1);
        wait_busy("rst");
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_addr", 32'(vif.rd_addr), 0);
        check("rst_mid_strobes", {vif.rd_en, vif.ld_go, active, frame_done, overrun}, 0);
        check("rst_mid_coords", {vif.ld_stax, vif.ld_stay, vif.ld_endx, vif.ld_endy}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);

        // DRAW(4,4) twice: second segment is degenerate (1 busy cycle)
        mem[0] = ent(OP_DRAW, 4, 4);
        mem[1] = ent(OP_DRAW, 4, 4);
        mem[2] = ent(OP_END, 0, 0);
        seg_dur = 3;
        g0 = go_cnt; d0 = done_cnt; q0 = go_q.size();
        start_frame("b", t1);
        wait_done("b", d0);
        check("b_done_cycle", cyc_of(t_done, t1), 18);
        check("b_seg0", go_at(q0), {8'd0, 8'd0, 8'd4, 8'd4});
        check("b_seg1", go_at(q0 + 1), {8'd4, 8'd4, 8'd4, 8'd4});
        tick(50);
        check("b_go_count", go_cnt - g0, 2);
        check("b_done_count", done_cnt - d0, 1);
        check("b_stable", stab_err, 0);

        // no END: list wraps, overrun is set and stays set
        mem[0] = ent(OP_NOP, 0, 0);
        mem[1] = ent(OP_NOP, 0, 0);
        mem[2] = ent(OP_NOP, 0, 0);
        mem[3] = ent(OP_MOVE, 1, 1);
        g0 = go_cnt; d0 = done_cnt;
        start_frame("ovr", t1);
        wait_done("ovr", d0);
        check("ovr_done_cycle", cyc_of(t_done, t1), 13);
        check("ovr_flag", overrun, 1);
        check("ovr_pen", {vif.ld_stax, vif.ld_stay}, {8'd1, 8'd1});
        tick(50);
        check("ovr_go_count", go_cnt - g0, 0);
        check("ovr_done_count", done_cnt - d0, 1);

        load_list_a();
        seg_dur = 5;
        g0 = go_cnt; d0 = done_cnt; q0 = go_q.size();
        start_frame("sticky", t1);
        check("sticky_flag_t1", overrun, 1);
        check("sticky_pen_t1", {vif.ld_stax, vif.ld_stay}, 0);
        wait_done("sticky", d0);
        check("sticky_seg", go_at(q0), {8'd10, 8'd20, 8'd30, 8'd5});
        check("sticky_flag_end", overrun, 1);
        tick(10);
        check("sticky_go_count", go_cnt - g0, 1);
        check("blank_track", blank_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
